// File: rtl/ripple_counter_ctrl_if.sv
// ripple_counter_ctrl_if: command handshake plus external ripple-counter lines.
//   cmd_valid/cmd_ready/cmd_op/cmd_n : command channel (valid/ready)
//   ctr_q                            : counter outputs back into the controller
//   ctr_clk/ctr_rst/ctr_j/ctr_k      : drive lines to the JK ripple counter
//   count_out/count_vld/done/err     : completion and sampled result
// master = environment side (command issuer and the counter itself),
// slave  = the controller.
interface ripple_counter_ctrl_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned NW    = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [NW-1:0]    cmd_n;
  logic [WIDTH-1:0] ctr_q;
  logic             ctr_clk;
  logic             ctr_rst;
  logic [WIDTH-1:0] ctr_j;
  logic [WIDTH-1:0] ctr_k;
  logic [WIDTH-1:0] count_out;
  logic             count_vld;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_n, ctr_q,
    input  cmd_ready, ctr_clk, ctr_rst, ctr_j, ctr_k, count_out, count_vld, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_n, ctr_q,
    output cmd_ready, ctr_clk, ctr_rst, ctr_j, ctr_k, count_out, count_vld, done, err
  );
endinterface

// File: rtl/ripple_counter_ctrl.sv
// ripple_counter_ctrl: sequencer for an external JK ripple up-counter.
// Accepts COUNT/CLEAR/READ commands, pulses the counter clock, waits a
// ripple-settle window, then samples the counter into the clk domain.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset (also forces ctr_rst high)
//   bus  : ripple_counter_ctrl_if.slave (command channel, counter lines, result)
// Build option: define RIPPLE_SHADOW_CHECK_EN to add a synchronous shadow
// count that is compared with every sample (sticky err flag); otherwise err=0.
module ripple_counter_ctrl #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned NW         = 8,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ripple_counter_ctrl_if.slave bus
);
  localparam int unsigned TW       = 4;
  localparam logic [1:0]  OP_COUNT = 2'b00;
  localparam logic [1:0]  OP_CLEAR = 2'b01;

  typedef enum logic [2:0] {
    IDLE, CLEAR, PULSE_HI, PULSE_LO, SETTLE, SAMPLE, DONE
  } state_t;

  state_t           state_q, state_nx;
  logic [NW-1:0]    rem_q, rem_nx;
  logic [TW-1:0]    tmr_q, tmr_nx;
  logic             is_count_q, is_count_nx;
  logic             cmd_ready_q, cmd_ready_nx;
  logic             ctr_clk_q, ctr_clk_nx;
  logic             ctr_rst_q, ctr_rst_nx;
  logic             jk_q, jk_nx;
  logic             done_q, done_nx;
  logic [WIDTH-1:0] count_out_q, count_out_nx;

  // State register; outputs are registered from the next-state decode so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      tmr_q       <= '0;
      is_count_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      ctr_clk_q   <= 1'b0;
      ctr_rst_q   <= 1'b1;
      jk_q        <= 1'b0;
      done_q      <= 1'b0;
      count_out_q <= '0;
    end else begin
      state_q     <= state_nx;
      rem_q       <= rem_nx;
      tmr_q       <= tmr_nx;
      is_count_q  <= is_count_nx;
      cmd_ready_q <= cmd_ready_nx;
      ctr_clk_q   <= ctr_clk_nx;
      ctr_rst_q   <= ctr_rst_nx;
      jk_q        <= jk_nx;
      done_q      <= done_nx;
      count_out_q <= count_out_nx;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nx    = state_q;
    rem_nx      = rem_q;
    is_count_nx = is_count_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          is_count_nx = (bus.cmd_op == OP_COUNT);
          rem_nx      = (bus.cmd_op == OP_COUNT) ? bus.cmd_n : '0;
          if (bus.cmd_op == OP_CLEAR)
            state_nx = CLEAR;
          else if (bus.cmd_op == OP_COUNT && bus.cmd_n != '0)
            state_nx = PULSE_HI;
          else
            state_nx = SAMPLE;   // READ, op 11, or COUNT of zero pulses
        end
      end
      CLEAR:    if (tmr_q == TW'(1)) state_nx = SETTLE;
      PULSE_HI: begin
        rem_nx   = rem_q - NW'(1);
        state_nx = PULSE_LO;
      end
      PULSE_LO: state_nx = SETTLE;
      SETTLE:   if (tmr_q == TW'(SETTLE_CYC - 1)) state_nx = SAMPLE;
      SAMPLE:   state_nx = (rem_q != '0) ? PULSE_HI : DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase

    // tmr counts cycles spent in the current state.
    tmr_nx = (state_nx != state_q) ? '0 : tmr_q + TW'(1);

    cmd_ready_nx = (state_nx == IDLE);
    ctr_clk_nx   = (state_nx == PULSE_HI);
    ctr_rst_nx   = (state_nx == CLEAR);
    jk_nx        = is_count_nx &&
                   (state_nx == PULSE_HI || state_nx == PULSE_LO || state_nx == SETTLE);
    done_nx      = (state_nx == DONE);
    // ctr_q is asynchronous but has been stable for the whole settle window.
    count_out_nx = (state_q == SAMPLE) ? bus.ctr_q : count_out_q;
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.ctr_clk   = ctr_clk_q;
  assign bus.ctr_rst   = ctr_rst_q;
  assign bus.ctr_j     = {WIDTH{jk_q}};
  assign bus.ctr_k     = {WIDTH{jk_q}};
  assign bus.done      = done_q;
  assign bus.count_vld = done_q;
  assign bus.count_out = count_out_q;

`ifdef RIPPLE_SHADOW_CHECK_EN
  logic [WIDTH-1:0] shadow_q;
  logic             err_q;

  // Shadow count mirrors every pulse; a sample mismatch sets err and resyncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.cmd_valid && bus.cmd_op == OP_CLEAR)
        err_q <= 1'b0;
      if (state_q == PULSE_HI)
        shadow_q <= shadow_q + WIDTH'(1);
      else if (state_q == CLEAR)
        shadow_q <= '0;
      else if (state_q == SAMPLE && bus.ctr_q != shadow_q) begin
        err_q    <= 1'b1;
        shadow_q <= bus.ctr_q;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_ripple_counter_ctrl.sv
// tb_ripple_counter_ctrl: directed bench for ripple_counter_ctrl with a
// behavioural JK ripple counter and a cycle-level reference model.
module tb_ripple_counter_ctrl;
  localparam int WIDTH = 3;
  localparam int NW    = 8;
  localparam int S     = 4;
  localparam int P     = 3 + S;
  localparam int MODV  = 1 << WIDTH;
`ifdef RIPPLE_SHADOW_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ripple_counter_ctrl_if #(.WIDTH(WIDTH), .NW(NW)) bus ();

  ripple_counter_ctrl #(.WIDTH(WIDTH), .NW(NW), .SETTLE_CYC(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External counter: toggles on the falling edge of ctr_clk when J=K=1.
  logic [WIDTH-1:0] ctr_val = '0;
  bit               stuck = 1'b0;
  logic [WIDTH-1:0] stuck_val = '0;

  always @(negedge bus.ctr_clk or posedge bus.ctr_rst) begin
    if (bus.ctr_rst)
      ctr_val <= '0;
    else if (bus.ctr_j == '1 && bus.ctr_k == '1 && !stuck)
      ctr_val <= ctr_val + 3'd1;
  end

  assign bus.ctr_q = stuck ? stuck_val : ctr_val;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle expectations derived from the command schedule.
  int cyc = 0;
  int t0 = 0, tdone = 0, m_n = 0;
  bit busy = 0, m_count = 0, m_clear = 0, rst_prev = 0;
  int m_cnt = 0, m_sh = 0, m_out = 0, m_err = 0, r_out = 0, r_err = 0;

  initial begin
    forever begin
      int off, obs, nsamp;
      bit in_pulse, e_clk, e_jk, e_rst, e_ready, e_done;
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy  = 0;
        m_cnt = 0;
        m_sh  = 0;
        m_out = 0;
        m_err = 0;
      end else begin
        if (busy && cyc > tdone) busy = 0;
        if (!busy && bus.cmd_valid) begin
          t0      = cyc;
          m_count = (bus.cmd_op == 2'b00);
          m_clear = (bus.cmd_op == 2'b01);
          m_n     = m_count ? int'(bus.cmd_n) : 0;
          r_err   = m_clear ? 0 : m_err;
          if (m_clear) begin
            m_cnt = 0;
            m_sh  = 0;
          end
          if (m_n > 0)      tdone = t0 + 1 + m_n * P;
          else if (m_clear) tdone = t0 + 4 + S;
          else              tdone = t0 + 2;
          nsamp = (m_n > 0) ? m_n : 1;
          for (int k = 0; k < nsamp; k++) begin
            if (m_n > 0) begin
              if (!stuck) m_cnt = (m_cnt + 1) % MODV;
              m_sh = (m_sh + 1) % MODV;
            end
            obs = stuck ? int'(stuck_val) : m_cnt;
            if (EN && obs != m_sh) begin
              r_err = 1;
              m_sh  = obs;
            end
            r_out = obs;
          end
          busy = 1;
        end
      end

      off      = cyc - t0 - 1;
      in_pulse = busy && m_count && off >= 0 && off < m_n * P;
      e_clk    = in_pulse && (off % P == 0);
      e_jk     = in_pulse && (off % P <= 1 + S);
      e_rst    = rst || rst_prev || (busy && m_clear && (off == 0 || off == 1));
      e_ready  = !(busy && cyc > t0);
      e_done   = busy && cyc == tdone;

      chk("cmd_ready", int'(bus.cmd_ready), int'(e_ready));
      chk("ctr_clk",   int'(bus.ctr_clk),   int'(e_clk));
      chk("ctr_rst",   int'(bus.ctr_rst),   int'(e_rst));
      chk("ctr_j",     int'(bus.ctr_j),     e_jk ? MODV - 1 : 0);
      chk("ctr_k",     int'(bus.ctr_k),     e_jk ? MODV - 1 : 0);
      chk("done",      int'(bus.done),      int'(e_done));
      chk("count_vld", int'(bus.count_vld), int'(e_done));
      if (!busy || cyc == t0) begin
        chk("count_out_idle", int'(bus.count_out), m_out);
        chk("err_idle",       int'(bus.err),       m_err);
      end
      if (e_done) begin
        chk("count_out_done", int'(bus.count_out), r_out);
        chk("err_done",       int'(bus.err),       r_err);
        m_out = r_out;
        m_err = r_err;
      end
      rst_prev = rst;
    end
  end

  // Issue one command; report cycles from acceptance to done and the result.
  task automatic send(input logic [1:0] op, input int n, input bit keep,
                      output int lat, output int val, output int e);
    bit seen = 0;
    lat = -1;
    val = -1;
    e   = -1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_n     = NW'(n);
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        lat  = k;
        val  = int'(bus.count_out);
        e    = int'(bus.err);
        if (!keep) bus.cmd_valid = 1'b0;
      end
    end
    if (!seen) begin
      bus.cmd_valid = 1'b0;
      chk("done_timeout", 0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int lat, val, e;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_n     = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_ctr_rst",   int'(bus.ctr_rst),   1);
    chk("rst_ctr_clk",   int'(bus.ctr_clk),   0);
    chk("rst_done",      int'(bus.done),      0);
    chk("rst_count_out", int'(bus.count_out), 0);
    chk("rst_err",       int'(bus.err),       0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // COUNT 5 from zero
    send(2'b00, 5, 0, lat, val, e);
    chk("t1_latency", lat, 36);
    chk("t1_value",   val, 5);
    chk("t1_err",     e,   0);

    // COUNT 4 wraps 7 -> 0 -> 1
    send(2'b00, 4, 0, lat, val, e);
    chk("t2_latency", lat, 29);
    chk("t2_value",   val, 1);
    chk("t2_err",     e,   0);

    // CLEAR
    send(2'b01, 0, 0, lat, val, e);
    chk("t3_latency", lat, 8);
    chk("t3_value",   val, 0);

    // Counter stuck at 2, then COUNT 1 and READ; CLEAR after release
    stuck_val = 3'd2;
    stuck     = 1'b1;
    send(2'b00, 1, 0, lat, val, e);
    chk("t4_latency", lat, 8);
    chk("t4_value",   val, 2);
    chk("t4_err",     e,   EN ? 1 : 0);
    send(2'b10, 0, 0, lat, val, e);
    chk("t4_read_latency", lat, 2);
    chk("t4_read_err",     e,   EN ? 1 : 0);
    stuck = 1'b0;
    send(2'b01, 0, 0, lat, val, e);
    chk("t4_clear_value", val, 0);
    chk("t4_clear_err",   e,   0);

    // Reset during COUNT 10, after the third pulse has settled
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_n     = NW'(10);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("t5_pulses_before_rst", int'(bus.ctr_q), 3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_ctr_clk",   int'(bus.ctr_clk),   0);
    chk("t5_ctr_rst",   int'(bus.ctr_rst),   1);
    chk("t5_cmd_ready", int'(bus.cmd_ready), 1);
    chk("t5_done",      int'(bus.done),      0);
    chk("t5_ctr_q",     int'(bus.ctr_q),     0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(2'b10, 0, 0, lat, val, e);
    chk("t5_read_latency", lat, 2);
    chk("t5_read_value",   val, 0);

    // COUNT 0 and op 11 back-to-back with cmd_valid held through DONE
    send(2'b00, 3, 0, lat, val, e);
    chk("t6_count3_latency", lat, 22);
    chk("t6_count3_value",   val, 3);
    send(2'b00, 0, 1, lat, val, e);
    chk("t6_count0_latency", lat, 2);
    chk("t6_count0_value",   val, 3);
    send(2'b11, 5, 0, lat, val, e);
    chk("t6_op11_latency", lat, 2);
    chk("t6_op11_value",   val, 3);
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
